// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline-register control slice.
// Stage codes, stall-vector bit positions, NOP encoding, shadow helper.
package pipe_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        HOLD  = 2'b01,
        RSV   = 2'b10,
        FLUSH = 2'b11
    } stg_code_e;

    localparam int STL_PC    = 7;
    localparam int STL_IFID  = 6;
    localparam int STL_IDEX  = 4;
    localparam int STL_EXMEM = 2;
    localparam int STL_MEMWB = 0;

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    // Reserved code behaves like HOLD for the shadow bit.
    function automatic logic vld_next(stg_code_e c, logic cur, logic up);
        logic r;
        case (c)
            RUN:     r = up;
            FLUSH:   r = 1'b0;
            default: r = cur;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/pipe_ctrl_sat_cnt.sv
// Saturating up-counter with synchronous clear (clear wins over inc).
// Ports: clk, rst_n (async low), clr, inc, q[W-1:0].
module sat_cnt #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr)
            q_d = '0;
        else if (inc && (q_q != '1))
            q_d = q_q + W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q_q <= '0;
        else
            q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Decodes the hazard stall/flush vector into pipeline register strobes,
// tracks per-stage valid shadows, perf counters, err and hold watchdog.
// In: i_clk, i_rst_n, i_stall[7:0], i_fetch_vld, i_cnt_clr.
// Out: enables/flushes, o_vld_*, o_*_cnt, o_err, o_deadlock.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter int MAX_HOLD = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [7:0]       i_stall,
    input  logic             i_fetch_vld,
    input  logic             i_cnt_clr,
    output logic             o_pc_en,
    output logic             o_ifid_en,
    output logic             o_idex_en,
    output logic             o_exmem_en,
    output logic             o_memwb_en,
    output logic             o_ifid_flush,
    output logic             o_idex_flush,
    output logic             o_exmem_flush,
    output logic             o_vld_id,
    output logic             o_vld_ex,
    output logic             o_vld_mem,
    output logic             o_vld_wb,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt,
    output logic [CNT_W-1:0] o_retire_cnt,
    output logic             o_err,
    output logic             o_deadlock
);

    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LIM = HW'(MAX_HOLD - 1);

    stg_code_e ifid_c, idex_c, exmem_c;
    logic pc_hold, wb_hold;
    logic any_flush, any_rsv;

    assign ifid_c  = stg_code_e'(i_stall[STL_IFID  -: 2]);
    assign idex_c  = stg_code_e'(i_stall[STL_IDEX  -: 2]);
    assign exmem_c = stg_code_e'(i_stall[STL_EXMEM -: 2]);
    assign pc_hold = i_stall[STL_PC];
    assign wb_hold = i_stall[STL_MEMWB];

    assign o_pc_en       = ~pc_hold;
    assign o_ifid_en     = (ifid_c  == RUN);
    assign o_idex_en     = (idex_c  == RUN);
    assign o_exmem_en    = (exmem_c == RUN);
    assign o_memwb_en    = ~wb_hold;
    assign o_ifid_flush  = (ifid_c  == FLUSH);
    assign o_idex_flush  = (idex_c  == FLUSH);
    assign o_exmem_flush = (exmem_c == FLUSH);

    assign any_flush = o_ifid_flush | o_idex_flush | o_exmem_flush;
    assign any_rsv   = (ifid_c == RSV) | (idex_c == RSV) | (exmem_c == RSV);

    logic vld_id_q, vld_ex_q, vld_mem_q, vld_wb_q;
    logic vld_id_d, vld_ex_d, vld_mem_d, vld_wb_d;
    logic err_q, err_d;
    logic dl_q, dl_d;
    logic [HW-1:0] hold_q, hold_d;

    always_comb begin
        vld_id_d  = vld_next(ifid_c,  vld_id_q,  i_fetch_vld);
        vld_ex_d  = vld_next(idex_c,  vld_ex_q,  vld_id_q);
        vld_mem_d = vld_next(exmem_c, vld_mem_q, vld_ex_q);
        vld_wb_d  = wb_hold ? vld_wb_q : vld_mem_q;
        err_d     = err_q | any_rsv;
    end

    // Run length pins at the limit; deadlock latches on the trip cycle.
    always_comb begin
        hold_d = hold_q;
        dl_d   = dl_q;
        if (!pc_hold) begin
            hold_d = '0;
        end else if (hold_q == HOLD_LIM) begin
            dl_d = 1'b1;
        end else begin
            hold_d = hold_q + HW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_id_q  <= 1'b0;
            vld_ex_q  <= 1'b0;
            vld_mem_q <= 1'b0;
            vld_wb_q  <= 1'b0;
            err_q     <= 1'b0;
            dl_q      <= 1'b0;
            hold_q    <= '0;
        end else begin
            vld_id_q  <= vld_id_d;
            vld_ex_q  <= vld_ex_d;
            vld_mem_q <= vld_mem_d;
            vld_wb_q  <= vld_wb_d;
            err_q     <= err_d;
            dl_q      <= dl_d;
            hold_q    <= hold_d;
        end
    end

    assign o_vld_id   = vld_id_q;
    assign o_vld_ex   = vld_ex_q;
    assign o_vld_mem  = vld_mem_q;
    assign o_vld_wb   = vld_wb_q;
    assign o_err      = err_q;
    assign o_deadlock = dl_q;

    sat_cnt #(.W(CNT_W)) u_stall_cnt (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .clr   (i_cnt_clr),
        .inc   (pc_hold),
        .q     (o_stall_cnt)
    );

    sat_cnt #(.W(CNT_W)) u_flush_cnt (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .clr   (i_cnt_clr),
        .inc   (any_flush),
        .q     (o_flush_cnt)
    );

    sat_cnt #(.W(CNT_W)) u_retire_cnt (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .clr   (i_cnt_clr),
        .inc   (vld_wb_q & ~wb_hold),
        .q     (o_retire_cnt)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with CNT_W=4, MAX_HOLD=4.
// Strobes packed {pc,ifid,idex,exmem,memwb,ifidf,idexf,exmemf}.
module tb_pipe_ctrl;

    localparam int CW = 4;
    localparam int MH = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [7:0]    stall;
    logic          fetch;
    logic          clr;
    logic          pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic          ifid_fl, idex_fl, exmem_fl;
    logic          v_id, v_ex, v_mem, v_wb;
    logic [CW-1:0] s_cnt, f_cnt, r_cnt;
    logic          err, dl;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.CNT_W(CW), .MAX_HOLD(MH)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_stall       (stall),
        .i_fetch_vld   (fetch),
        .i_cnt_clr     (clr),
        .o_pc_en       (pc_en),
        .o_ifid_en     (ifid_en),
        .o_idex_en     (idex_en),
        .o_exmem_en    (exmem_en),
        .o_memwb_en    (memwb_en),
        .o_ifid_flush  (ifid_fl),
        .o_idex_flush  (idex_fl),
        .o_exmem_flush (exmem_fl),
        .o_vld_id      (v_id),
        .o_vld_ex      (v_ex),
        .o_vld_mem     (v_mem),
        .o_vld_wb      (v_wb),
        .o_stall_cnt   (s_cnt),
        .o_flush_cnt   (f_cnt),
        .o_retire_cnt  (r_cnt),
        .o_err         (err),
        .o_deadlock    (dl)
    );

    wire [7:0] strb = {pc_en, ifid_en, idex_en, exmem_en,
                       memwb_en, ifid_fl, idex_fl, exmem_fl};
    wire [3:0] vld  = {v_id, v_ex, v_mem, v_wb};

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_regs_zero(input string tag);
        chk({tag, "_vld"}, 32'(vld), 32'h0);
        chk({tag, "_scnt"}, 32'(s_cnt), 32'h0);
        chk({tag, "_fcnt"}, 32'(f_cnt), 32'h0);
        chk({tag, "_rcnt"}, 32'(r_cnt), 32'h0);
        chk({tag, "_err"}, 32'(err), 32'h0);
        chk({tag, "_dl"}, 32'(dl), 32'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        stall = 8'h00;
        fetch = 1'b0;
        clr   = 1'b0;
        #2;
        chk_regs_zero("rst");
        stall = 8'h80;
        #1 chk("rst_strb_pc", 32'(strb), 32'h78);
        stall = 8'h01;
        #1 chk("rst_strb_wb", 32'(strb), 32'hF0);
        #8;
        // t=12: release, fill pipeline
        rst_n = 1'b1;
        stall = 8'h00;
        fetch = 1'b1;
        #1 chk("run_strb", 32'(strb), 32'hF8);
        tick();
        chk("fill1", 32'(vld), 32'h8);
        tick();
        chk("fill2", 32'(vld), 32'hC);
        tick();
        chk("fill3", 32'(vld), 32'hE);
        tick();
        chk("fill4", 32'(vld), 32'hF);
        chk("fill4_ret", 32'(r_cnt), 32'h0);
        tick();
        chk("fill5_ret", 32'(r_cnt), 32'h1);

        // load-use
        stall = 8'hAE;
        #1 chk("lu_strb", 32'(strb), 32'h09);
        tick();
        chk("lu_vld", 32'(vld), 32'hD);
        chk("lu_scnt", 32'(s_cnt), 32'h1);
        chk("lu_fcnt", 32'(f_cnt), 32'h1);
        chk("lu_rcnt", 32'(r_cnt), 32'h2);

        // refill
        stall = 8'h00;
        tick();
        chk("rf1_vld", 32'(vld), 32'hE);
        chk("rf1_rcnt", 32'(r_cnt), 32'h3);
        tick();
        chk("rf2_vld", 32'(vld), 32'hF);
        chk("rf2_rcnt", 32'(r_cnt), 32'h3);

        // branch flush with fetch valid in same cycle
        stall = 8'h7E;
        #1 chk("br_strb", 32'(strb), 32'h8F);
        tick();
        chk("br_vld", 32'(vld), 32'h1);
        chk("br_fcnt", 32'(f_cnt), 32'h2);
        chk("br_scnt", 32'(s_cnt), 32'h1);
        chk("br_rcnt", 32'(r_cnt), 32'h4);

        // reserved IF/ID code
        fetch = 1'b0;
        stall = 8'h40;
        #1 chk("rsv_strb", 32'(strb), 32'hB8);
        chk("rsv_err0", 32'(err), 32'h0);
        tick();
        chk("rsv_err1", 32'(err), 32'h1);
        chk("rsv_rcnt", 32'(r_cnt), 32'h5);
        stall = 8'h00;
        tick();
        chk("rsv_sticky", 32'(err), 32'h1);
        chk("rsv_vld", 32'(vld), 32'h0);

        // watchdog: 3 holds do not trip
        stall = 8'h80;
        repeat (3) tick();
        chk("wd3_dl", 32'(dl), 32'h0);
        chk("wd3_scnt", 32'(s_cnt), 32'h4);
        stall = 8'h00;
        tick();
        chk("wd_gap_dl", 32'(dl), 32'h0);
        stall = 8'h80;
        repeat (3) tick();
        chk("wd4a_dl", 32'(dl), 32'h0);
        tick();
        chk("wd4b_dl", 32'(dl), 32'h1);
        chk("wd4_strb", 32'(strb), 32'h78);
        chk("wd4_scnt", 32'(s_cnt), 32'h8);

        // saturation and clear
        repeat (20) tick();
        chk("sat_scnt", 32'(s_cnt), 32'hF);
        clr = 1'b1;
        tick();
        chk("clr_scnt", 32'(s_cnt), 32'h0);
        chk("clr_fcnt", 32'(f_cnt), 32'h0);
        chk("clr_rcnt", 32'(r_cnt), 32'h0);
        clr = 1'b0;
        tick();
        chk("post_clr", 32'(s_cnt), 32'h1);
        chk("post_dl", 32'(dl), 32'h1);

        // async reset mid-cycle
        #3 rst_n = 1'b0;
        #1;
        chk_regs_zero("mid_rst");
        chk("mid_rst_strb", 32'(strb), 32'h78);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
